request_sequencer: RTL and testbench
====================================

REQUEST_SEQUENCER -- requirements
Module: request_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request FIFO entries.
REQ-002 SHALL have parameter CAPACITY, default 3: garage occupancy limit, compared against gFull.
REQ-003 SHALL have parameter TIMEOUT, default 1024: cycles allowed for each interlock phase.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port arriveBtn, input, 1: raw asynchronous arrival button.
REQ-007 SHALL have port departBtn, input, 1: raw asynchronous departure button.
REQ-008 SHALL have port arriving, input, 1: interlock arrival-in-progress status.
REQ-009 SHALL have port departing, input, 1: interlock departure-in-progress status.
REQ-010 SHALL have port gFull, input, 2: current garage occupancy, 0..3.
REQ-011 SHALL have port arriveCtrl, output, 1: one-cycle arrival command pulse to the interlock.
REQ-012 SHALL have port departCtrl, output, 1: one-cycle departure command pulse.
REQ-013 SHALL have port queueCount, output, 3: FIFO occupancy, 0..DEPTH.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port rejectPulse, output, 1: one-cycle pulse on any dropped request.
REQ-016 SHALL have port timeoutErr, output, 1: sticky error flag.

Function
REQ-017 SHALL synchronize each button through 2 flops, then rising-edge detect; a push occurs 3 cycles after a button rise.
REQ-018 SHALL push one 1-bit entry per edge: 0 = arrive, 1 = depart. Order is FIFO.
REQ-019 On simultaneous arrive and depart edges, SHALL push depart only, drop the arrival, and pulse rejectPulse.
REQ-020 A push when the FIFO holds DEPTH entries SHALL be dropped with rejectPulse; FIFO contents unchanged.
REQ-021 SHALL allow push and pop in the same cycle; queueCount is then unchanged.
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT_START, WAIT_DONE, ERROR.
REQ-023 IDLE with FIFO non-empty SHALL pop the head and go to ISSUE; IDLE with FIFO empty SHALL stay in IDLE.
REQ-024 ISSUE SHALL check the popped entry against gFull as sampled that cycle:
  - arrive with gFull>=CAPACITY -> rejectPulse, return to IDLE, no command;
  - depart with gFull==0 -> rejectPulse, return to IDLE, no command;
  - otherwise assert the matching Ctrl for exactly that cycle, then go to WAIT_START.
REQ-025 WAIT_START SHALL wait for the matching status (arriving or departing) to go high, then go to WAIT_DONE.
REQ-026 WAIT_DONE SHALL wait for that status to go low, then go to IDLE; a new dispatch occurs no earlier than the following cycle.
REQ-027 A single phase counter SHALL clear on entry to each WAIT state; reaching TIMEOUT-1 without the awaited event SHALL move the FSM to ERROR.
REQ-028 ERROR SHALL set timeoutErr=1 and hold it until reset.
REQ-029 In ERROR, no further commands SHALL be issued, the FIFO SHALL freeze, and every new push SHALL be rejected.
REQ-030 Status changes of the non-matching type SHALL be ignored in both WAIT states.
REQ-031 arriveCtrl and departCtrl SHALL never be high in the same cycle.

Reset
REQ-032 rst low SHALL asynchronously clear: FSM to IDLE, FIFO empty, synchronizers and edge registers to 0, phase counter 0.
REQ-033 During reset, all outputs SHALL be 0: arriveCtrl, departCtrl, queueCount, busy, rejectPulse, timeoutErr.
REQ-034 Reset asserted mid-operation SHALL abandon the current request; no Ctrl pulse is emitted on or after reset release until a new edge is queued.
REQ-035 The first synchronized edge SHALL be detected no earlier than 3 cycles after rst deasserts.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the request-type encoding (ARRIVE=0, DEPART=1), and the default CAPACITY and TIMEOUT constants.
REQ-037 The FIFO SHALL be a separate sub-module, req_fifo: 1-bit data, DEPTH parameter, push, pop, count, full, empty.

Verification
REQ-038 Single arrive press with gFull=0 -> arriveCtrl pulse 4 cycles after the button rise; arriving high 5 cycles then low -> IDLE, queueCount=0.
REQ-039 Five arrive presses while the first is in progress -> 4 queued, fifth drops with rejectPulse, queueCount=4, then drains one at a time.
REQ-040 Arrive request popped with gFull=3 -> rejectPulse, no arriveCtrl; depart request with gFull=0 -> rejectPulse, no departCtrl.
REQ-041 arriving never rises after the command, TIMEOUT=16 -> ERROR after 16 cycles, timeoutErr=1; a subsequent press is rejected.
REQ-042 Both buttons rise together -> a single departCtrl pulse and one rejectPulse.
REQ-043 rst low in WAIT_DONE with 2 entries queued -> all outputs 0 immediately; no Ctrl pulses after release.

Source files
------------

// File: rtl/request_sequencer_pkg.sv
// Shared types and defaults for the request sequencer and its FIFO.
package request_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic {
    REQ_ARRIVE = 1'b0,
    REQ_DEPART = 1'b1
  } req_e;

  localparam int unsigned DEF_CAPACITY = 3;
  localparam int unsigned DEF_TIMEOUT  = 1024;

  // Width of a counter that must hold 0..limit-1.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Small 1-bit request FIFO; push when full and pop when empty are ignored.
module req_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    dout    = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = bump(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = bump(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/request_sequencer.sv
// Queues arrive/depart button presses and dispatches them one at a time to
// the garage interlock, guarding each handshake phase with a timeout.
module request_sequencer
  import request_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CAPACITY = DEF_CAPACITY,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriveBtn,
  input  logic       departBtn,
  input  logic       arriving,
  input  logic       departing,
  input  logic [1:0] gFull,
  output logic       arriveCtrl,
  output logic       departCtrl,
  output logic [2:0] queueCount,
  output logic       busy,
  output logic       rejectPulse,
  output logic       timeoutErr
);

  localparam int unsigned QW = $clog2(DEPTH + 1);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  logic [1:0]    arr_sync_q, arr_sync_d, dep_sync_q, dep_sync_d;
  logic          arr_prev_q, arr_prev_d, dep_prev_q, dep_prev_d;
  state_e        state_q, state_d;
  req_e          req_q, req_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          arr_edge, dep_edge, push_req, push_ok, pop;
  logic          push_bit, fifo_dout, fifo_full, fifo_empty;
  logic [QW-1:0] fifo_count;
  logic          arr_ctrl, dep_ctrl, issue_rej, status, cnt_limit;

  always_comb begin
    arr_sync_d = {arr_sync_q[0], arriveBtn};
    dep_sync_d = {dep_sync_q[0], departBtn};
    arr_prev_d = arr_sync_q[1];
    dep_prev_d = dep_sync_q[1];
    arr_edge   = arr_sync_q[1] & ~arr_prev_q;
    dep_edge   = dep_sync_q[1] & ~dep_prev_q;
  end

  // A simultaneous pair queues the departure; the arrival is the one dropped.
  always_comb begin
    push_req = arr_edge | dep_edge;
    push_bit = dep_edge;
    push_ok  = push_req & ~fifo_full & (state_q != ST_ERROR);
    pop      = (state_q == ST_IDLE) & ~fifo_empty;
  end

  req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst),
    .push (push_ok),
    .pop  (pop),
    .din  (push_bit),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    status    = (req_q == REQ_DEPART) ? departing : arriving;
    cnt_limit = (cnt_q == TW'(TIMEOUT - 1));
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    arr_ctrl  = 1'b0;
    dep_ctrl  = 1'b0;
    issue_rej = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          req_d   = req_e'(fifo_dout);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if ((req_q == REQ_ARRIVE) && (32'(gFull) >= CAPACITY)) begin
          issue_rej = 1'b1;
          state_d   = ST_IDLE;
        end else if ((req_q == REQ_DEPART) && (gFull == '0)) begin
          issue_rej = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          arr_ctrl = (req_q == REQ_ARRIVE);
          dep_ctrl = (req_q == REQ_DEPART);
          cnt_d    = '0;
          state_d  = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (status) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_limit) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!status) begin
          state_d = ST_IDLE;
        end else if (cnt_limit) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arriveCtrl  = arr_ctrl;
    departCtrl  = dep_ctrl;
    queueCount  = 3'(fifo_count);
    busy        = (state_q != ST_IDLE);
    timeoutErr  = (state_q == ST_ERROR);
    rejectPulse = (arr_edge & dep_edge) | (push_req & ~push_ok) | issue_rej;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arr_sync_q <= '0;
      dep_sync_q <= '0;
      arr_prev_q <= 1'b0;
      dep_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      req_q      <= REQ_ARRIVE;
      cnt_q      <= '0;
    end else begin
      arr_sync_q <= arr_sync_d;
      dep_sync_q <= dep_sync_d;
      arr_prev_q <= arr_prev_d;
      dep_prev_q <= dep_prev_d;
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_request_sequencer.sv
// Scoreboard bench: expected command/reject events queued by stimulus,
// checked with their cycle stamps by an independent monitor.
module tb_request_sequencer;

  localparam logic [2:0] EV_ARR = 3'b001;
  localparam logic [2:0] EV_DEP = 3'b010;
  localparam logic [2:0] EV_REJ = 3'b100;

  typedef struct {
    logic [2:0] ev;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arriveBtn = 1'b0;
  logic       departBtn = 1'b0;
  logic       arriving;
  logic       departing;
  logic [1:0] gFull = 2'd0;
  logic       arriveCtrl, departCtrl, busy, rejectPulse, timeoutErr;
  logic [2:0] queueCount;

  logic resp_en   = 1'b1;
  int   resp_dly  = 1;
  int   resp_hold = 5;

  request_sequencer #(
    .DEPTH   (4),
    .CAPACITY(3),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arriveBtn  (arriveBtn),
    .departBtn  (departBtn),
    .arriving   (arriving),
    .departing  (departing),
    .gFull      (gFull),
    .arriveCtrl (arriveCtrl),
    .departCtrl (departCtrl),
    .queueCount (queueCount),
    .busy       (busy),
    .rejectPulse(rejectPulse),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Interlock model: raise status resp_dly cycles after a command, hold resp_hold cycles.
  initial begin
    logic is_dep;
    arriving  = 1'b0;
    departing = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && (arriveCtrl || departCtrl)) begin
        is_dep = departCtrl;
        repeat (resp_dly) @(negedge clk);
        if (is_dep) departing = 1'b1;
        else        arriving  = 1'b1;
        repeat (resp_hold) @(negedge clk);
        arriving  = 1'b0;
        departing = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] seen;
    exp_t       e;
    seen = {rejectPulse, departCtrl, arriveCtrl};
    if (seen !== 3'b000) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d got=%b expected=none", cyc, seen);
      end else begin
        e = exp_q.pop_front();
        if (seen !== e.ev || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL event cyc=%0d got=%b expected=%b at cyc %0d", cyc, seen, e.ev, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_arriveCtrl"}, arriveCtrl, 0);
    check({tag, "_departCtrl"}, departCtrl, 0);
    check({tag, "_queueCount"}, queueCount, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rejectPulse"}, rejectPulse, 0);
    check({tag, "_timeoutErr"}, timeoutErr, 0);
  endtask

  task automatic expect_ev(input logic [2:0] ev, input int c);
    exp_t e;
    e.ev  = ev;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic a, input logic d);
    arriveBtn = a;
    departBtn = d;
    repeat (2) @(negedge clk);
    arriveBtn = 1'b0;
    departBtn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, m, p, q, r;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single arrival, command 4 cycles after the button rise
    n = cyc;
    expect_ev(EV_ARR, n + 4);
    press(1'b1, 1'b0);
    wait_until(n + 6);
    check("busy_in_wait", busy, 1);
    wait_until(n + 12);
    check("busy_after_done", busy, 0);
    check("qcount_after_done", queueCount, 0);

    // Burst of five presses behind an in-progress arrival
    resp_dly  = 12;
    resp_hold = 12;
    n = cyc;
    expect_ev(EV_ARR, n + 4);
    expect_ev(EV_REJ, n + 22);
    expect_ev(EV_ARR, n + 30);
    expect_ev(EV_ARR, n + 56);
    expect_ev(EV_ARR, n + 82);
    expect_ev(EV_ARR, n + 108);
    repeat (6) press(1'b1, 1'b0);
    wait_until(n + 24);
    check("qcount_full", queueCount, 4);
    wait_until(n + 31);
    check("qcount_drain3", queueCount, 3);
    wait_until(n + 57);
    check("qcount_drain2", queueCount, 2);
    wait_until(n + 136);
    check("qcount_drained", queueCount, 0);
    check("busy_drained", busy, 0);

    // Occupancy gating at dispatch time
    resp_dly  = 1;
    resp_hold = 5;
    gFull = 2'd3;
    n = cyc;
    expect_ev(EV_REJ, n + 4);
    press(1'b1, 1'b0);
    wait_until(n + 6);
    gFull = 2'd0;
    m = cyc;
    expect_ev(EV_REJ, m + 4);
    press(1'b0, 1'b1);
    wait_until(m + 6);
    gFull = 2'd2;
    p = cyc;
    expect_ev(EV_DEP, p + 4);
    press(1'b0, 1'b1);
    wait_until(p + 12);
    q = cyc;
    expect_ev(EV_ARR, q + 4);
    press(1'b1, 1'b0);
    wait_until(q + 12);
    check("busy_after_gating", busy, 0);

    // Simultaneous arrive and depart edges
    gFull = 2'd1;
    n = cyc;
    expect_ev(EV_REJ, n + 2);
    expect_ev(EV_DEP, n + 4);
    press(1'b1, 1'b1);
    wait_until(n + 12);
    check("qcount_after_both", queueCount, 0);
    check("busy_after_both", busy, 0);

    // Interlock never answers: timeout into ERROR
    resp_en = 1'b0;
    gFull   = 2'd0;
    n = cyc;
    expect_ev(EV_ARR, n + 4);
    press(1'b1, 1'b0);
    wait_until(n + 20);
    check("timeout_not_yet", timeoutErr, 0);
    wait_until(n + 21);
    check("timeout_set", timeoutErr, 1);
    wait_until(n + 22);
    m = cyc;
    expect_ev(EV_REJ, m + 2);
    press(1'b1, 1'b0);
    wait_until(m + 10);
    check("timeout_sticky", timeoutErr, 1);
    check("qcount_in_error", queueCount, 0);
    check("busy_in_error", busy, 1);

    rst = 1'b0;
    #1;
    check("error_cleared", timeoutErr, 0);
    @(negedge clk);
    rst     = 1'b1;
    resp_en = 1'b1;

    // Reset while in WAIT_DONE with two requests queued
    resp_dly  = 12;
    resp_hold = 12;
    repeat (3) @(negedge clk);
    n = cyc;
    expect_ev(EV_ARR, n + 4);
    repeat (3) press(1'b1, 1'b0);
    wait_until(n + 20);
    check("qcount_before_reset", queueCount, 2);
    check("busy_before_reset", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_until(n + 70);

    // Button already high across reset release
    resp_dly  = 1;
    resp_hold = 5;
    rst       = 1'b0;
    arriveBtn = 1'b1;
    @(negedge clk);
    r   = cyc;
    rst = 1'b1;
    expect_ev(EV_ARR, r + 4);
    wait_until(r + 2);
    arriveBtn = 1'b0;
    wait_until(r + 14);
    check("busy_after_release", busy, 0);
    check("qcount_after_release", queueCount, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
